sum_2d: RTL and testbench

SUM_2D -- requirements
Module: sum_2d

---
 rtl/mean_filter_pkg.sv | 18 +
 rtl/sum_2d_if.sv | 14 +
 rtl/line_buf.sv | 36 +++
 rtl/sum_2d.sv | 188 ++++++++++++++++++
 tb/tb_sum_2d.sv | 166 ++++++++++++++++
 5 files changed

// File: rtl/mean_filter_pkg.sv
// Shared constants for the mean-filter datapath (sum_2d and the downstream divider).
// Holds the legal kernel sizes, the sum-width derivation and the fixed pipeline latency.
package mean_filter_pkg;

    // Clocks from an input pixel to its window sum at the output.
    localparam int unsigned PIPE_LATENCY = 3;

    // Only odd kernels 3, 5 and 7 are supported.
    function automatic bit ksz_legal(input int unsigned ksz);
        return (ksz == 3) || (ksz == 5) || (ksz == 7);
    endfunction

    // Bits needed to hold ksz*ksz full-scale pixels without overflow.
    function automatic int unsigned sum_width(input int unsigned ksz, input int unsigned dw);
        return $clog2(ksz * ksz * ((1 << dw) - 1) + 1);
    endfunction

endpackage

// File: rtl/sum_2d_if.sv
// Video stream bundle: frame valid, line valid and pixel data.
//   vsync : frame valid
//   hsync : line valid, data meaningful while high
//   data  : pixel or window sum, W bits
interface sum_2d_if #(
    parameter int unsigned W = 8
);
    logic         vsync;
    logic         hsync;
    logic [W-1:0] data;

    modport master (output vsync, hsync, data);
    modport slave  (input  vsync, hsync, data);
endinterface

// File: rtl/line_buf.sv
// One video line of storage with a registered read port and a write port.
// A read and a write to the same address in one cycle return the old contents.
//   clk     : clock
//   rd_en   : load rd_data from rd_addr
//   rd_addr : read address
//   rd_data : registered read data
//   wr_en   : write wr_data to wr_addr
//   wr_addr : write address
//   wr_data : write data
module line_buf #(
    parameter  int unsigned DEPTH = 640,
    parameter  int unsigned W     = 8,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [W-1:0]  rd_data,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [W-1:0]  wr_data
);

    logic [W-1:0] mem [DEPTH];

    // Contents are intentionally not reset; consumers gate stale rows.
    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

endmodule

// File: rtl/sum_2d.sv
// KSZ x KSZ window sum over a raster video stream, fixed 3-clock latency.
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset
//   din  : input stream (vsync, hsync, DW-bit pixel)
//   dout : output stream, syncs delayed 3 clocks, SW-bit sum (0 outside hsync)
// Stage 0 tracks row/column and issues line-buffer reads one cycle early so
// the stored rows line up with the registered pixel in stage 1.
module sum_2d
    import mean_filter_pkg::*;
#(
    parameter int unsigned KSZ   = 3,
    parameter int unsigned DW    = 8,
    parameter int unsigned IMG_W = 640,
    parameter int unsigned SW    = 16
) (
    input  logic     clk,
    input  logic     rst,
    sum_2d_if.slave  din,
    sum_2d_if.master dout
);

    localparam int unsigned NLB = KSZ - 1;
    localparam int unsigned CW  = $clog2(IMG_W);
    localparam int unsigned RW  = $clog2(KSZ);

    if (!ksz_legal(KSZ)) begin : g_ksz_check
        $error("sum_2d: KSZ must be 3, 5 or 7");
    end

    // Stage 0: edge detect and position tracking
    logic          vs_d;
    logic          hs_d;
    logic [CW-1:0] col_q;
    logic [RW-1:0] row_q;
    logic          vs_rise_c;
    logic          hs_rise_c;
    logic          hs_fall_c;
    logic [CW-1:0] col_c;
    logic [RW-1:0] row_c;

    always_comb begin
        vs_rise_c = din.vsync & ~vs_d;
        hs_rise_c = din.hsync & ~hs_d;
        hs_fall_c = ~din.hsync & hs_d;
        // Position of the pixel on the bus this cycle, edges taking effect at once.
        col_c     = hs_rise_c ? '0 : col_q;
        row_c     = vs_rise_c ? '0 : row_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vs_d  <= 1'b0;
            hs_d  <= 1'b0;
            col_q <= '0;
            row_q <= '0;
        end else begin
            vs_d <= din.vsync;
            hs_d <= din.hsync;
            if (din.hsync) begin
                col_q <= (col_c == CW'(IMG_W - 1)) ? '0 : col_c + CW'(1);
            end
            if (vs_rise_c) begin
                row_q <= '0;
            end else if (hs_fall_c && (row_c != RW'(KSZ - 1))) begin
                row_q <= row_c + RW'(1);
            end
        end
    end

    // Stage 1: registered input and position
    logic          s1_vs;
    logic          s1_hs;
    logic          s1_first;
    logic [DW-1:0] s1_pix;
    logic [CW-1:0] s1_col;
    logic [RW-1:0] s1_row;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_vs    <= 1'b0;
            s1_hs    <= 1'b0;
            s1_first <= 1'b0;
            s1_pix   <= '0;
            s1_col   <= '0;
            s1_row   <= '0;
        end else begin
            s1_vs    <= din.vsync;
            s1_hs    <= din.hsync;
            s1_first <= hs_rise_c;
            s1_pix   <= din.data;
            s1_col   <= col_c;
            s1_row   <= row_c;
        end
    end

    // Line-buffer chain: buffer k holds row r-1-k; each shifts its old word to the next.
    logic [DW-1:0] lb_rd [NLB];

    for (genvar k = 0; k < NLB; k++) begin : g_lb
        logic [DW-1:0] wr_data_c;
        if (k == 0) begin : g_head
            assign wr_data_c = s1_pix;
        end else begin : g_tail
            assign wr_data_c = lb_rd[k-1];
        end
        line_buf #(
            .DEPTH (IMG_W),
            .W     (DW)
        ) u_lb (
            .clk     (clk),
            .rd_en   (din.hsync),
            .rd_addr (col_c),
            .rd_data (lb_rd[k]),
            .wr_en   (s1_hs),
            .wr_addr (s1_col),
            .wr_data (wr_data_c)
        );
    end

    // Stage 2: vertical column sum, rows not yet seen this frame count as zero
    logic [SW-1:0] colsum_c;
    logic          s2_vs;
    logic          s2_hs;
    logic          s2_first;
    logic [SW-1:0] s2_colsum;

    always_comb begin
        colsum_c = '0;
        if (s1_hs) begin
            colsum_c = SW'(s1_pix);
            for (int k = 0; k < int'(NLB); k++) begin
                if (k < int'(s1_row)) begin
                    colsum_c = colsum_c + SW'(lb_rd[k]);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_vs     <= 1'b0;
            s2_hs     <= 1'b0;
            s2_first  <= 1'b0;
            s2_colsum <= '0;
        end else begin
            s2_vs     <= s1_vs;
            s2_hs     <= s1_hs;
            s2_first  <= s1_first;
            s2_colsum <= colsum_c;
        end
    end

    // Stage 3: horizontal sum of the current and previous KSZ-1 column sums
    logic [SW-1:0] hist_q [NLB];
    logic [SW-1:0] hsum_c;

    always_comb begin
        hsum_c = s2_colsum;
        if (!s2_first) begin
            for (int j = 0; j < int'(NLB); j++) begin
                hsum_c = hsum_c + hist_q[j];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout.vsync <= 1'b0;
            dout.hsync <= 1'b0;
            dout.data  <= '0;
            for (int j = 0; j < int'(NLB); j++) begin
                hist_q[j] <= '0;
            end
        end else begin
            dout.vsync <= s2_vs;
            dout.hsync <= s2_hs;
            dout.data  <= s2_hs ? hsum_c : '0;
            if (s2_hs) begin
                // First pixel of a line drops history from the previous line.
                hist_q[0] <= s2_colsum;
                for (int j = 1; j < int'(NLB); j++) begin
                    hist_q[j] <= s2_first ? '0 : hist_q[j-1];
                end
            end
        end
    end

endmodule

// File: tb/tb_sum_2d.sv
// Bench for sum_2d: three instances (KSZ 3, 5, 7) share one input stream;
// expected outputs come from a frame image and a direct window-sum model.
module tb_sum_2d;

    localparam int unsigned DW    = 8;
    localparam int unsigned SW    = 16;
    localparam int unsigned IMG_W = 32;
    localparam int unsigned MAXR  = 8;

    typedef struct packed {
        logic            vs;
        logic            hs;
        logic [2:0][15:0] d;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sum_2d_if #(.W(DW)) din_bus ();
    sum_2d_if #(.W(SW)) o3 ();
    sum_2d_if #(.W(SW)) o5 ();
    sum_2d_if #(.W(SW)) o7 ();

    sum_2d #(.KSZ(3), .DW(DW), .IMG_W(IMG_W), .SW(SW)) u_k3 (.clk(clk), .rst(rst), .din(din_bus), .dout(o3));
    sum_2d #(.KSZ(5), .DW(DW), .IMG_W(IMG_W), .SW(SW)) u_k5 (.clk(clk), .rst(rst), .din(din_bus), .dout(o5));
    sum_2d #(.KSZ(7), .DW(DW), .IMG_W(IMG_W), .SW(SW)) u_k7 (.clk(clk), .rst(rst), .din(din_bus), .dout(o7));

    int          n_vec = 0;
    int          n_err = 0;
    int          cyc   = 0;
    int unsigned peak7 = 0;
    int unsigned img [MAXR][IMG_W];
    exp_t        q [$];

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Reference: sum of the KSZ x KSZ window ending at (r,c), out-of-frame terms zero.
    function automatic int unsigned win_sum(input int k, input int r, input int c);
        int unsigned s = 0;
        for (int i = 0; i < k; i++) begin
            for (int j = 0; j < k; j++) begin
                if ((r - i >= 0) && (c - j >= 0)) begin
                    s += img[r-i][c-j];
                end
            end
        end
        return s;
    endfunction

    task automatic check_outs(input string pfx, input exp_t e);
        check($sformatf("%s k3_vsync@%0d", pfx, cyc), 32'(o3.vsync), 32'(e.vs));
        check($sformatf("%s k3_hsync@%0d", pfx, cyc), 32'(o3.hsync), 32'(e.hs));
        check($sformatf("%s k3_dout@%0d",  pfx, cyc), 32'(o3.data),  32'(e.d[0]));
        check($sformatf("%s k5_vsync@%0d", pfx, cyc), 32'(o5.vsync), 32'(e.vs));
        check($sformatf("%s k5_hsync@%0d", pfx, cyc), 32'(o5.hsync), 32'(e.hs));
        check($sformatf("%s k5_dout@%0d",  pfx, cyc), 32'(o5.data),  32'(e.d[1]));
        check($sformatf("%s k7_vsync@%0d", pfx, cyc), 32'(o7.vsync), 32'(e.vs));
        check($sformatf("%s k7_hsync@%0d", pfx, cyc), 32'(o7.hsync), 32'(e.hs));
        check($sformatf("%s k7_dout@%0d",  pfx, cyc), 32'(o7.data),  32'(e.d[2]));
    endtask

    // One clock: check outputs for the input of three clocks ago, then drive new input.
    task automatic step(input logic vs, input logic hs, input logic [7:0] px, input int r, input int c);
        exp_t e;
        @(posedge clk);
        #1;
        cyc++;
        if (q.size() == 3) begin
            e = q.pop_front();
            check_outs("pipe", e);
            if (32'(o7.data) > peak7) peak7 = 32'(o7.data);
        end
        din_bus.vsync = vs;
        din_bus.hsync = hs;
        din_bus.data  = hs ? px : 8'd0;
        e = '0;
        e.vs = vs;
        e.hs = hs;
        if (hs) begin
            img[r][c] = 32'(px);
            for (int i = 0; i < 3; i++) e.d[i] = 16'(win_sum(3 + 2 * i, r, c));
        end
        q.push_back(e);
    endtask

    // mode 0: random, 1: constant val, 2: ramp c + 10r
    task automatic frame(input int rows, input int cols, input int mode, input int val,
                         input int gap_lo, input int gap_hi);
        logic [7:0] px;
        step(1'b1, 1'b0, 8'd0, 0, 0);
        step(1'b1, 1'b0, 8'd0, 0, 0);
        for (int r = 0; r < rows; r++) begin
            for (int c = 0; c < cols; c++) begin
                case (mode)
                    0:       px = 8'($urandom_range(0, 255));
                    1:       px = 8'(val);
                    default: px = 8'(c + 10 * r);
                endcase
                step(1'b1, 1'b1, px, r, c);
            end
            repeat (int'($urandom_range(gap_lo, gap_hi))) step(1'b1, 1'b0, 8'd0, 0, 0);
        end
        repeat (3) step(1'b0, 1'b0, 8'd0, 0, 0);
    endtask

    task automatic zero_inputs;
        din_bus.vsync = 1'b0;
        din_bus.hsync = 1'b0;
        din_bus.data  = '0;
    endtask

    // Reset pulse in the middle of a line; outputs must drop before the next edge.
    task automatic reset_mid;
        step(1'b1, 1'b0, 8'd0, 0, 0);
        for (int c = 0; c < 4; c++) step(1'b1, 1'b1, 8'($urandom_range(0, 255)), 0, c);
        @(posedge clk);
        #2;
        rst = 1'b1;
        zero_inputs();
        #1;
        check_outs("midrst", '0);
        @(posedge clk);
        #2;
        rst = 1'b0;
        q.delete();
        repeat (3) q.push_back('0);
    endtask

    initial begin
        rst = 1'b1;
        zero_inputs();
        repeat (2) @(posedge clk);
        #1;
        check_outs("reset", '0);
        #1;
        rst = 1'b0;
        repeat (3) q.push_back('0);

        frame(4, 4, 1, 1, 1, 1);
        peak7 = 0;
        frame(8, 8, 1, 255, 1, 3);
        check("k7_peak", peak7, 32'd12495);
        frame(3, 3, 1, 200, 1, 2);
        frame(3, 3, 1, 1, 1, 2);
        frame(4, 6, 0, 0, 1, 1);
        frame(4, 6, 0, 0, 5, 5);
        frame(6, 6, 2, 0, 1, 4);
        for (int n = 0; n < 3; n++) begin
            frame(int'($urandom_range(1, MAXR)), int'($urandom_range(1, 12)), 0, 0, 1, 5);
        end
        reset_mid();
        frame(5, 7, 0, 0, 1, 3);
        repeat (4) step(1'b0, 1'b0, 8'd0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
